// File: rtl/fp_pkg.sv
// fp_pkg: rounding modes, flag indices, binary32 constants and the
// stage-1 to stage-2 payload of the FP normalise/round back end.
package fp_pkg;

  localparam logic [2:0] RM_RNE = 3'b000;
  localparam logic [2:0] RM_RTZ = 3'b001;
  localparam logic [2:0] RM_RDN = 3'b010;
  localparam logic [2:0] RM_RUP = 3'b011;
  localparam logic [2:0] RM_RMM = 3'b100;

  localparam int FF_NV = 4;
  localparam int FF_DZ = 3;
  localparam int FF_OF = 2;
  localparam int FF_UF = 1;
  localparam int FF_NX = 0;

  localparam logic [31:0] QNAN     = 32'h7FC00000;
  localparam logic [30:0] INF_MAG  = 31'h7F800000;
  localparam logic [30:0] MAXF_MAG = 31'h7F7FFFFF;

  typedef struct packed {
    logic        sign;
    logic        zero;
    logic [48:0] sum;
    logic [7:0]  e;
    logic [2:0]  rm;
    logic [5:0]  lzc;
    logic        is_nan;
    logic        nv;
    logic        is_inf;
  } s1_t;

  function automatic logic round_up(
    input logic [2:0] rm,
    input logic       sign,
    input logic       lsb,
    input logic       grd,
    input logic       stk
  );
    logic r;
    case (rm)
      RM_RTZ:  r = 1'b0;
      RM_RDN:  r = (grd | stk) & sign;
      RM_RUP:  r = (grd | stk) & ~sign;
      RM_RMM:  r = grd;
      default: r = grd & (stk | lsb);
    endcase
    return r;
  endfunction

endpackage

// File: rtl/lzc48.sv
// lzc48: leading-zero count of a 48-bit word, plus an all-zero flag.
// An all-zero input reports a count of 48.
module lzc48 (
  input  logic [47:0] data_i,
  output logic [5:0]  cnt_o,
  output logic        zero_o
);

  always_comb begin
    cnt_o = 6'd48;
    for (int i = 0; i < 48; i++) begin
      if (data_i[i]) cnt_o = 6'(47 - i);
    end
  end

  assign zero_o = ~|data_i;

endmodule

// File: rtl/fp_norm_round_r4.sv
// fp_norm_round_r4: add/sub, normalise, round and pack binary32.
// Two registered stages with valid/ready on both sides.
module fp_norm_round_r4
  import fp_pkg::*;
#(
  parameter logic [31:0] CANON_NAN = QNAN
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        sign1,
  input  logic        sign2,
  input  logic [7:0]  exp_res,
  input  logic [47:0] mantissa1_aligned,
  input  logic [47:0] mantissa2_aligned,
  input  logic        nan_in,
  input  logic        inf1,
  input  logic        inf2,
  input  logic [2:0]  rm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] result,
  output logic [4:0]  fflags
);

  s1_t         s1_d, s1_q;
  logic        s1_valid_q, s2_valid_q;
  logic [31:0] res_d, res_q;
  logic [4:0]  ff_d, ff_q;
  logic        s2_adv;

  assign s2_adv   = !s2_valid_q || out_ready;
  assign in_ready = !s1_valid_q || s2_adv;

  logic        m1_ge;
  logic [48:0] sum;
  logic [5:0]  lzc;
  logic        lz_zero;
  logic        is_zero;
  logic        inf_nv;

  always_comb begin
    m1_ge = mantissa1_aligned >= mantissa2_aligned;
    if (sign1 == sign2)
      sum = {1'b0, mantissa1_aligned} + {1'b0, mantissa2_aligned};
    else if (m1_ge)
      sum = {1'b0, mantissa1_aligned} - {1'b0, mantissa2_aligned};
    else
      sum = {1'b0, mantissa2_aligned} - {1'b0, mantissa1_aligned};
  end

  lzc48 u_lzc (
    .data_i (sum[47:0]),
    .cnt_o  (lzc),
    .zero_o (lz_zero)
  );

  assign is_zero = lz_zero && !sum[48];
  assign inf_nv  = inf1 && inf2 && (sign1 != sign2);

  always_comb begin
    s1_d        = '0;
    s1_d.sum    = sum;
    s1_d.lzc    = lzc;
    s1_d.zero   = is_zero;
    s1_d.e      = (exp_res == 8'd0) ? 8'd1 : exp_res;
    s1_d.rm     = rm;
    s1_d.is_nan = nan_in || inf_nv;
    s1_d.nv     = !nan_in && inf_nv;
    s1_d.is_inf = inf1 || inf2;
    // Zero from cancellation is +0 except under round-down.
    if (inf1)
      s1_d.sign = sign1;
    else if (inf2)
      s1_d.sign = sign2;
    else if (is_zero)
      s1_d.sign = (sign1 == sign2) ? sign1 : (rm == RM_RDN);
    else
      s1_d.sign = (sign1 == sign2 || m1_ge) ? sign1 : sign2;
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      s1_valid_q <= 1'b0;
      s1_q       <= '0;
    end else if (in_ready) begin
      s1_valid_q <= in_valid;
      if (in_valid) s1_q <= s1_d;
    end
  end

  logic [7:0]  em1, sh;
  logic [47:0] norm;
  logic        xbit;
  logic [9:0]  ex, expf;
  logic        subn, grd, stk, inc, nx, of, tiny, use_max;
  logic [32:0] rnd;

  always_comb begin
    em1  = s1_q.e - 8'd1;
    sh   = ({2'b00, s1_q.lzc} < em1) ? {2'b00, s1_q.lzc} : em1;
    norm = s1_q.sum[47:0];
    xbit = 1'b0;
    ex   = {2'b00, s1_q.e};
    if (s1_q.sum[48]) begin
      norm = s1_q.sum[48:1];
      xbit = s1_q.sum[0];
      ex   = ex + 10'd1;
    end else begin
      norm = s1_q.sum[47:0] << sh[5:0];
      ex   = ex - {2'b00, sh};
    end
    subn = !norm[47];
    expf = subn ? 10'd0 : ex;
    grd  = norm[23];
    stk  = (|norm[22:0]) | xbit;
    inc  = round_up(s1_q.rm, s1_q.sign, norm[24], grd, stk);
    // Carry out of the fraction ripples straight into the exponent.
    rnd  = {expf, norm[46:24]} + {32'd0, inc};
    nx   = grd | stk;
    of   = rnd[32:23] >= 10'd255;
    // Tiny unless rounding at full precision reaches 2^-126.
    tiny = subn && !((&norm[46:23]) &&
           round_up(s1_q.rm, s1_q.sign, norm[23], norm[22],
                    (|norm[21:0]) | xbit));
    use_max = (s1_q.rm == RM_RTZ) ||
              (s1_q.rm == RM_RDN && !s1_q.sign) ||
              (s1_q.rm == RM_RUP && s1_q.sign);
    res_d = {s1_q.sign, rnd[30:0]};
    ff_d  = '0;
    ff_d[FF_NX] = nx;
    ff_d[FF_UF] = nx && tiny;
    if (s1_q.is_nan) begin
      res_d = CANON_NAN;
      ff_d  = '0;
      ff_d[FF_NV] = s1_q.nv;
    end else if (s1_q.is_inf) begin
      res_d = {s1_q.sign, INF_MAG};
      ff_d  = '0;
    end else if (s1_q.zero) begin
      res_d = {s1_q.sign, 31'd0};
      ff_d  = '0;
    end else if (of) begin
      res_d = {s1_q.sign, use_max ? MAXF_MAG : INF_MAG};
      ff_d  = '0;
      ff_d[FF_OF] = 1'b1;
      ff_d[FF_NX] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      s2_valid_q <= 1'b0;
      res_q      <= '0;
      ff_q       <= '0;
    end else if (s2_adv) begin
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        res_q <= res_d;
        ff_q  <= ff_d;
      end
    end
  end

  assign out_valid = s2_valid_q;
  assign result    = res_q;
  assign fflags    = ff_q;

endmodule

// File: tb/tb_fp_norm_round_r4.sv
// tb_fp_norm_round_r4: directed and random stimulus against an exact
// integer rounding model, with an in-order scoreboard.
module tb_fp_norm_round_r4;

  logic        clk = 1'b0;
  logic        reset, flush, in_valid, in_ready;
  logic        sign1, sign2, nan_in, inf1, inf2;
  logic [7:0]  exp_res;
  logic [47:0] m1, m2;
  logic [2:0]  rm;
  logic        out_valid, out_ready;
  logic [31:0] result;
  logic [4:0]  fflags;

  int          n_chk = 0;
  int          n_err = 0;
  logic [36:0] sbq[$];
  bit          stalled;

  always #5 clk = ~clk;

  fp_norm_round_r4 dut (
    .clk               (clk),
    .reset             (reset),
    .flush             (flush),
    .in_valid          (in_valid),
    .in_ready          (in_ready),
    .sign1             (sign1),
    .sign2             (sign2),
    .exp_res           (exp_res),
    .mantissa1_aligned (m1),
    .mantissa2_aligned (m2),
    .nan_in            (nan_in),
    .inf1              (inf1),
    .inf2              (inf2),
    .rm                (rm),
    .out_valid         (out_valid),
    .out_ready         (out_ready),
    .result            (result),
    .fflags            (fflags)
  );

  task automatic chk(input string name, input logic [36:0] act,
                     input logic [36:0] want);
    n_chk++;
    if (act !== want) begin
      n_err++;
      $display("FAIL %s: got %h want %h", name, act, want);
    end
  endtask

  // Round s * 2^e to a multiple of 2^(e+sh).
  function automatic longint rnd(input longint s, input int sh,
                                 input int rmx, input logic sg);
    longint q, r, h;
    logic up;
    if (sh <= 0) return s << (-sh);
    q = s >> sh;
    r = s - (q << sh);
    h = longint'(1) << (sh - 1);
    case (rmx)
      1:       up = 1'b0;
      2:       up = sg && (r != 0);
      3:       up = !sg && (r != 0);
      4:       up = (r >= h);
      default: up = (r > h) || (r == h && q[0]);
    endcase
    return q + (up ? longint'(1) : longint'(0));
  endfunction

  function automatic logic [36:0] model(
    input logic sa, input logic sb, input logic [7:0] er,
    input logic [47:0] a, input logic [47:0] b,
    input logic nan, input logic ia, input logic ib, input logic [2:0] rmi);
    longint s, q, qu, one;
    int     e, p, ulp, rmx, ef;
    logic   sg, inx, tiny, use_max;
    one = 1;
    rmx = (rmi > 3'd4) ? 0 : int'(rmi);
    if (nan) return {5'b00000, 32'h7FC00000};
    if (ia && ib && sa != sb) return {5'b10000, 32'h7FC00000};
    if (ia) return {5'b00000, sa, 31'h7F800000};
    if (ib) return {5'b00000, sb, 31'h7F800000};
    if (sa == sb) begin
      s = longint'(a) + longint'(b); sg = sa;
    end else if (a > b) begin
      s = longint'(a) - longint'(b); sg = sa;
    end else begin
      s = longint'(b) - longint'(a); sg = sb;
    end
    if (s == 0) return {5'b00000, (sa == sb) ? sa : (rmx == 2), 31'd0};
    e = ((er == 8'd0) ? 1 : int'(er)) - 174;
    p = 0;
    for (int i = 0; i < 49; i++) if (s[i]) p = i;
    ulp = ((p + e > -126) ? p + e : -126) - 23;
    q   = rnd(s, ulp - e, rmx, sg);
    inx = (ulp - e > 0) && ((s & ((one << (ulp - e)) - 1)) != 0);
    if (q == (one << 24)) begin
      q = one << 23;
      ulp++;
    end
    tiny = 1'b0;
    if (p + e < -126) begin
      qu   = rnd(s, p - 23, rmx, sg);
      tiny = !(p + e == -127 && qu == (one << 24));
    end
    ef = (q < (one << 23)) ? 0 : ulp + 150;
    if (ef >= 255) begin
      use_max = (rmx == 1) || (rmx == 2 && !sg) || (rmx == 3 && sg);
      return {5'b00101, sg, use_max ? 31'h7F7FFFFF : 31'h7F800000};
    end
    return {3'b000, inx && tiny, inx, sg, 8'(ef), 23'(q)};
  endfunction

  always @(negedge clk) begin
    if (!reset) begin
      if (in_valid && !in_ready) stalled = 1'b1;
      if (out_valid && out_ready) begin
        if (sbq.size() == 0) begin
          n_chk++;
          n_err++;
          $display("FAIL unexpected_out: got %h want none", {fflags, result});
        end else begin
          chk("scoreboard", {fflags, result}, sbq.pop_front());
        end
      end
      if (flush) sbq.delete();
      else if (in_valid && in_ready)
        sbq.push_back(model(sign1, sign2, exp_res, m1, m2,
                            nan_in, inf1, inf2, rm));
    end
  end

  task automatic apply(input logic sa, input logic sb, input logic [7:0] er,
                       input logic [47:0] a, input logic [47:0] b,
                       input logic nan, input logic ia, input logic ib,
                       input logic [2:0] r);
    sign1 = sa; sign2 = sb; exp_res = er; m1 = a; m2 = b;
    nan_in = nan; inf1 = ia; inf2 = ib; rm = r;
  endtask

  task automatic send();
    int g;
    g = 0;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && g < 100) begin
      @(negedge clk);
      g++;
    end
    if (!in_ready) chk("send_timeout", 37'd0, 37'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int g;
    g = 0;
    out_ready = 1'b1;
    @(negedge clk);
    while ((sbq.size() != 0 || out_valid) && g < 200) begin
      @(negedge clk);
      g++;
    end
    chk("drain", 37'(sbq.size()), 37'd0);
    @(posedge clk); #1;
  endtask

  task automatic dvec(input string name, input logic sa, input logic sb,
                      input logic [7:0] er, input logic [47:0] a,
                      input logic [47:0] b, input logic nan, input logic ia,
                      input logic ib, input logic [2:0] r,
                      input logic [36:0] lit);
    chk(name, model(sa, sb, er, a, b, nan, ia, ib, r), lit);
    apply(sa, sb, er, a, b, nan, ia, ib, r);
    send();
  endtask

  task automatic rand_in();
    logic [63:0] r1, r2;
    logic [47:0] a, b, t;
    int k;
    r1 = {$urandom, $urandom};
    r2 = {$urandom, $urandom};
    k  = int'($urandom_range(0, 7));
    case (k)
      0:       exp_res = 8'd0;
      1:       exp_res = 8'($urandom_range(1, 4));
      2:       exp_res = 8'($urandom_range(245, 254));
      default: exp_res = 8'($urandom_range(1, 254));
    endcase
    if (exp_res == 8'd0) a = r1[47:0] >> $urandom_range(1, 30);
    else a = r1[47:0] | 48'h800000000000;
    b = (r2[47:0] | 48'h800000000000) >> $urandom_range(0, 50);
    case ($urandom_range(0, 7))
      0: b = a;
      1: b = a - 48'($urandom_range(1, 5000));
      2: b = a >> 1;
      default: ;
    endcase
    if ($urandom_range(0, 1) == 1) begin
      t = a; a = b; b = t;
    end
    m1 = a; m2 = b;
    sign1  = 1'($urandom_range(0, 1));
    sign2  = 1'($urandom_range(0, 1));
    rm     = 3'($urandom_range(0, 7));
    nan_in = ($urandom_range(0, 31) == 0);
    inf1   = ($urandom_range(0, 31) == 0);
    inf2   = ($urandom_range(0, 31) == 0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen;
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    apply(0, 0, 8'd0, 48'd0, 48'd0, 0, 0, 0, 3'd0);
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", 37'(out_valid), 37'd0);
    chk("rst_result", 37'(result), 37'd0);
    chk("rst_fflags", 37'(fflags), 37'd0);
    chk("rst_in_ready", 37'(in_ready), 37'd1);

    @(posedge clk); #1;
    apply(0, 0, 8'd127, 48'h800000000000, 48'h800000000000, 0, 0, 0, 3'd0);
    in_valid = 1'b1;
    @(negedge clk);
    chk("lat_accept", 37'(in_ready), 37'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("lat_cycle1", 37'(out_valid), 37'd0);
    @(negedge clk);
    chk("lat_cycle2", 37'(out_valid), 37'd1);
    drain();

    dvec("add_1p1", 0, 0, 8'd127, 48'h800000000000, 48'h800000000000,
         0, 0, 0, 3'd0, {5'b00000, 32'h40000000});
    dvec("sub_rne", 0, 1, 8'd127, 48'h800000000000, 48'h800000000000,
         0, 0, 0, 3'd0, {5'b00000, 32'h00000000});
    dvec("sub_rdn", 0, 1, 8'd127, 48'h800000000000, 48'h800000000000,
         0, 0, 0, 3'd2, {5'b00000, 32'h80000000});
    dvec("ovf_rne", 0, 0, 8'd254, 48'hFFFFFF000000, 48'hFFFFFF000000,
         0, 0, 0, 3'd0, {5'b00101, 32'h7F800000});
    dvec("ovf_rtz", 0, 0, 8'd254, 48'hFFFFFF000000, 48'hFFFFFF000000,
         0, 0, 0, 3'd1, {5'b00101, 32'h7F7FFFFF});
    dvec("inf_inf", 0, 1, 8'd127, 48'd0, 48'd0,
         0, 1, 1, 3'd0, {5'b10000, 32'h7FC00000});
    dvec("nan", 0, 0, 8'd127, 48'd0, 48'd0,
         1, 0, 0, 3'd0, {5'b00000, 32'h7FC00000});
    dvec("tie_rne", 0, 0, 8'd127, 48'h800000800000, 48'd0,
         0, 0, 0, 3'd0, {5'b00001, 32'h3F800000});
    dvec("tie_rup", 0, 0, 8'd127, 48'h800000800000, 48'd0,
         0, 0, 0, 3'd3, {5'b00001, 32'h3F800001});
    dvec("tie_rmm", 0, 0, 8'd127, 48'h800000800000, 48'd0,
         0, 0, 0, 3'd4, {5'b00001, 32'h3F800001});
    dvec("sub_uf", 0, 0, 8'd1, 48'h000001800000, 48'd0,
         0, 0, 0, 3'd0, {5'b00011, 32'h00000002});
    dvec("tiny_after", 0, 0, 8'd1, 48'h7FFFFFFFFFFF, 48'd0,
         0, 0, 0, 3'd0, {5'b00001, 32'h00800000});
    dvec("tiny_rtz", 0, 0, 8'd1, 48'h7FFFFFFFFFFF, 48'd0,
         0, 0, 0, 3'd1, {5'b00011, 32'h007FFFFF});
    drain();

    stalled = 1'b0;
    out_ready = 1'b0;
    fork
      begin
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join_none
    for (int k = 0; k < 4; k++) begin
      apply(0, 0, 8'(120 + k), 48'h800000000000, 48'h800000000000,
            0, 0, 0, 3'd0);
      send();
    end
    chk("bp_stall", 37'(stalled), 37'd1);
    drain();

    out_ready = 1'b0;
    apply(0, 0, 8'd100, 48'h800000000000, 48'h400000000000, 0, 0, 0, 3'd0);
    send();
    apply(0, 0, 8'd101, 48'h800000000000, 48'h400000000000, 0, 0, 0, 3'd0);
    send();
    in_valid = 1'b1;
    flush = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    flush = 1'b0;
    @(negedge clk);
    chk("flush_valid", 37'(out_valid), 37'd0);
    chk("flush_result", 37'(result), 37'd0);
    out_ready = 1'b1;
    seen = 0;
    repeat (4) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    chk("flush_stale", 37'(seen), 37'd0);
    @(posedge clk); #1;

    for (int c = 0; c < 1500; c++) begin
      rand_in();
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 127) == 0);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    flush = 1'b0;
    drain();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
